msdf_otf_converter: RTL and testbench
=====================================

// Module: msdf_otf_converter
// PURPOSE
// - Converts the MSDF signed-digit product stream (Zj, ready_Zj) from the MSDF multiplier into a parallel
//   two's-complement word by on-the-fly conversion (OTFC): no carry-propagate adder, one digit per cycle.
// - Sits directly after the multiplier top, at the receiving end of its serial output.
// - Hands a parallel result to the host once all N+1 digits have arrived.
// PARAMETERS
// - N      9   operand index width, matching the multiplier; NDIG = N+1 digits per result (localparam)
// - W      derived localparam = N+2; result width, i.e. sign bit plus NDIG digit weights
// PORTS
// - clk       in   1    single clock; all state updates on rising edge
// - rst       in   1    asynchronous, active-high reset
// - start     in   1    1-cycle pulse; arms converter for a new product (same pulse given to multiplier)
// - Zj        in   2    signed digit, value = Zj[0] - Zj[1]: 01=+1, 10=-1, 00=0, 11=0
// - ready_Zj  in   1    Zj valid this cycle (multiplier output strobe)
// - P         out  W    converted result, two's complement integer; fraction value = P * 2^-NDIG
// - P_valid   out  1    P holds a complete result; cleared by start
// - done      out  1    1-cycle pulse, the cycle P first shows a new result
// - busy      out  1    high while in ACCUM
// BEHAVIOUR
// - Reset (async): state=IDLE, Q=0, QM=all ones, cnt=0, P=0, P_valid=0, done=0, busy=0.
// - FSM states:
//   - IDLE: on start -> ACCUM; Q<=0, QM<='1, cnt<=0, P_valid<=0.
//   - ACCUM: each cycle with ready_Zj=1 consumes one digit and cnt++; cycles with ready_Zj=0 hold all state.
//     When the digit at cnt==NDIG-1 is consumed: P<=final Q, P_valid<=1, done<=1 (next cycle), -> IDLE.
// - OTFC update per digit d, with shift-append s(R,b) = {R[W-2:0], b}:
//   - d=+1: Q<=s(Q,1),  QM<=s(Q,0)
//   - d= 0: Q<=s(Q,0),  QM<=s(QM,1)
//   - d=-1: Q<=s(QM,1), QM<=s(QM,0)
// - Invariant: QM == Q-1 (mod 2^W) after every update.
// - Width: |value| <= 2^NDIG-1 always fits W bits; no overflow detection needed.
// - Latency: done rises the cycle after the final digit's clock edge. Digits need not be contiguous.
// - Boundary conditions:
//   - ready_Zj while IDLE: ignored, no state change.
//   - start while ACCUM: restart; partial result discarded, cnt<=0, P_valid<=0.
//   - start and ready_Zj in the same cycle: start wins, digit not consumed.
//   - Final digit and start in the same cycle: start wins; no done, P unchanged.
//   - P, P_valid: stable in IDLE until the next start.
//   - Zj=11: decoded as 0, no error flag.
//   - rst asserted mid-operation: immediate return to reset values; a later start begins cleanly.
// STRUCTURE
// - Shared include msdf_defs.vh:
//   - digit encodings DIG_POS=2'b01, DIG_NEG=2'b10, DIG_ZERO=2'b00
//   - FSM state encodings ST_IDLE, ST_ACCUM
//   - shared by multiplier datapath and this block
// - Sub-module otf_step: combinational next-Q/next-QM from (Q, QM, Zj), parameterised on W.
// - Top of this block holds FSM, digit counter ($clog2(NDIG+1) bits), Q/QM registers, output register.
// TESTING (N=9, NDIG=10, W=11)
// - All +1: start, ten +1 digits back-to-back -> done 1 cycle after last digit, P=11'h3FF (1023).
// - All -1: start, ten -1 digits -> P=11'h401 (-1023), P_valid=1.
// - Mixed: +1,-1 then eight 0 -> P=11'h100 (256); +1,+1,-1 then 0s -> 11'h280 (640).
// - Bubbles: ready_Zj pattern 1,0,0,1,... carrying the mixed stream -> same P, done only after 10th digit.
// - Restart/ignore: start, 4 digits, start again, 10 zero digits -> P=0, exactly one done;
//   digits fed while IDLE leave P unchanged.
// - Reset: rst mid-stream -> all outputs 0 the same cycle; all-+1 run afterwards gives P=11'h3FF.
// - Self-check: every digit cycle, assert QM==Q-1 (mod 2^11); P equals reference sum of d_i*2^(10-i).

Source files
------------

// File: rtl/msdf_otf_converter_pkg.sv
// Shared definitions for the MSDF on-the-fly converter.
//   state_t    : converter FSM states
//   DIG_*      : raw 2-bit signed-digit encodings on Zj (value = Zj[0] - Zj[1])
//   digit_t    : decoded digit class
//   decode_digit() : maps a raw Zj code to its digit class (11 decodes as zero)
package msdf_otf_converter_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_ACCUM
  } state_t;

  localparam logic [1:0] DIG_ZERO = 2'b00;
  localparam logic [1:0] DIG_POS  = 2'b01;
  localparam logic [1:0] DIG_NEG  = 2'b10;

  typedef enum logic [1:0] {
    D_ZERO,
    D_POS,
    D_NEG
  } digit_t;

  function automatic digit_t decode_digit(input logic [1:0] zj);
    digit_t d;
    case (zj)
      DIG_POS: d = D_POS;
      DIG_NEG: d = D_NEG;
      default: d = D_ZERO;  // 00 and 11 both carry value 0
    endcase
    return d;
  endfunction

endpackage

// File: rtl/msdf_otf_converter_otf_step.sv
// otf_step: one combinational on-the-fly conversion step.
// Given the current Q and QM (= Q-1) registers and one signed digit,
// produces the next Q / QM by shift-append, never a carry-propagate add.
//   q, qm     in  W  current conversion registers
//   zj        in  2  signed digit (01=+1, 10=-1, 00/11=0)
//   q_next    out W  next Q
//   qm_next   out W  next QM
module otf_step
  import msdf_otf_converter_pkg::*;
#(
  parameter int unsigned W = 11
) (
  input  logic [W-1:0] q,
  input  logic [W-1:0] qm,
  input  logic [1:0]   zj,
  output logic [W-1:0] q_next,
  output logic [W-1:0] qm_next
);

  always_comb begin
    q_next  = {q[W-2:0], 1'b0};
    qm_next = {qm[W-2:0], 1'b1};
    case (decode_digit(zj))
      D_POS: begin
        q_next  = {q[W-2:0], 1'b1};
        qm_next = {q[W-2:0], 1'b0};
      end
      D_NEG: begin
        // borrow case: the new Q is built from QM so no carry ripples
        q_next  = {qm[W-2:0], 1'b1};
        qm_next = {qm[W-2:0], 1'b0};
      end
      default: begin
        q_next  = {q[W-2:0], 1'b0};
        qm_next = {qm[W-2:0], 1'b1};
      end
    endcase
  end

endmodule

// File: rtl/msdf_otf_converter.sv
// msdf_otf_converter: collects the NDIG = N+1 signed digits of an MSDF
// product stream and converts them on the fly into a W = N+2 bit
// two's-complement word (fraction value = P * 2^-NDIG).
//   clk       in   1  clock, rising edge
//   rst       in   1  asynchronous active-high reset
//   start     in   1  arms the converter for a new product (also restarts)
//   Zj        in   2  signed digit
//   ready_Zj  in   1  Zj valid this cycle
//   P         out  W  converted result
//   P_valid   out  1  P holds a complete result; cleared by start
//   done      out  1  one-cycle pulse when P first shows a new result
//   busy      out  1  high while digits are being accumulated
module msdf_otf_converter
  import msdf_otf_converter_pkg::*;
#(
  parameter  int unsigned N = 9,
  localparam int unsigned W = N + 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   Zj,
  input  logic         ready_Zj,
  output logic [W-1:0] P,
  output logic         P_valid,
  output logic         done,
  output logic         busy
);

  localparam int unsigned NDIG = N + 1;
  localparam int unsigned CW   = $clog2(NDIG + 1);

  state_t        state, state_next;
  logic [W-1:0]  q, qm;
  logic [W-1:0]  q_next, qm_next;
  logic [CW-1:0] cnt;
  logic          arm, consume, finish;

  otf_step #(.W(W)) u_step (
    .q       (q),
    .qm      (qm),
    .zj      (Zj),
    .q_next  (q_next),
    .qm_next (qm_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // start always takes priority over a digit arriving in the same cycle
  always_comb begin
    state_next = state;
    arm        = 1'b0;
    consume    = 1'b0;
    finish     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          arm        = 1'b1;
          state_next = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (start) begin
          arm = 1'b1;
        end else if (ready_Zj) begin
          consume = 1'b1;
          if (cnt == CW'(NDIG - 1)) begin
            finish     = 1'b1;
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q       <= '0;
      qm      <= '1;
      cnt     <= '0;
      P       <= '0;
      P_valid <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= finish;
      if (arm) begin
        q       <= '0;
        qm      <= '1;
        cnt     <= '0;
        P_valid <= 1'b0;
      end else if (consume) begin
        q   <= q_next;
        qm  <= qm_next;
        cnt <= finish ? '0 : cnt + CW'(1);
        if (finish) begin
          P       <= q_next;
          P_valid <= 1'b1;
        end
      end
    end
  end

  assign busy = (state == ST_ACCUM);

endmodule

// File: tb/tb_msdf_otf_converter.sv
// Scoreboard bench for msdf_otf_converter (N=9, NDIG=10, W=11).
// Stimulus pushes the hand-computed result of each complete product into
// exp_q; the monitor pops and compares whenever done pulses.
module tb_msdf_otf_converter;

  localparam logic [1:0] POS = 2'b01;
  localparam logic [1:0] NEG = 2'b10;
  localparam logic [1:0] ZRO = 2'b00;
  localparam logic [1:0] ALT = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  Zj;
  logic        ready_Zj;
  logic [10:0] P;
  logic        P_valid;
  logic        done;
  logic        busy;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;
  int unsigned done_cnt = 0;
  int unsigned push_cnt = 0;
  logic [10:0] exp_q[$];

  msdf_otf_converter #(.N(9)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .Zj       (Zj),
    .ready_Zj (ready_Zj),
    .P        (P),
    .P_valid  (P_valid),
    .done     (done),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [10:0] v);
    exp_q.push_back(v);
    push_cnt++;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // digits packed MSB-first: digit i lives at ds[19-2i -: 2]
  task automatic feed(input logic [19:0] ds, input int gap, input int count);
    for (int i = 0; i < count; i++) begin
      ready_Zj = 1'b1;
      Zj       = ds[19-2*i -: 2];
      tick();
      ready_Zj = 1'b0;
      Zj       = ZRO;
      if (i != count - 1) repeat (gap) tick();
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
  endtask

  // monitor: scoreboard compare on done, plus QM == Q-1 every busy cycle
  always @(negedge clk) begin
    logic [10:0] qm_ref;
    if (!rst) begin
      if (done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          chk("P", P, exp_q.pop_front());
          chk("P_valid_on_done", P_valid, 1);
        end
      end
      if (busy) begin
        qm_ref = dut.q - 11'd1;
        chk("qm_inv", dut.qm, qm_ref);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; Zj = ZRO; ready_Zj = 1'b0;
    #12;
    chk("rst_P", P, 0);
    chk("rst_P_valid", P_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    tick();

    // all +1 -> 1023
    do_start();
    chk("busy_accum", busy, 1);
    push_exp(11'h3FF);
    feed({10{POS}}, 0, 10);
    chk("done_latency", done, 1);
    chk("busy_after", busy, 0);
    wait_drain(); tick();

    // all -1 -> -1023
    do_start(); push_exp(11'h401);
    feed({10{NEG}}, 0, 10);
    wait_drain(); tick();
    chk("P_valid_hold", P_valid, 1);

    // +1,-1,0... -> 256
    do_start(); push_exp(11'h100);
    feed({POS, NEG, 16'h0}, 0, 10);
    wait_drain(); tick();

    // +1,+1,-1,0... -> 640
    do_start(); push_exp(11'h280);
    feed({POS, POS, NEG, 14'h0}, 0, 10);
    wait_drain(); tick();

    // asynchronous reset mid-stream
    do_start();
    feed({10{POS}}, 0, 5);
    rst = 1'b1;
    #1;
    chk("mid_rst_P", P, 0);
    chk("mid_rst_P_valid", P_valid, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_busy", busy, 0);
    rst = 1'b0;
    tick();
    do_start(); push_exp(11'h3FF);
    feed({10{POS}}, 0, 10);
    wait_drain(); tick();

    // bubbles 1,0,0 carrying +1,-1,0...; no done before the 10th digit
    do_start(); push_exp(11'h100);
    feed({POS, NEG, 16'h0}, 2, 9);
    repeat (2) tick();
    chk("bubble_no_early_done", done, 0);
    chk("bubble_P_valid_low", P_valid, 0);
    feed({ZRO, 18'h0}, 0, 1);
    chk("bubble_done", done, 1);
    wait_drain(); tick();

    // restart discards partial result; 11 decodes as zero
    do_start();
    feed({10{POS}}, 0, 4);
    do_start(); push_exp(11'h000);
    feed({ALT, ZRO, ALT, ZRO, ALT, ALT, ZRO, ZRO, ALT, ZRO}, 0, 10);
    wait_drain(); tick();

    // digits while IDLE are ignored
    feed({10{POS}}, 0, 3);
    tick();
    chk("idle_P", P, 0);
    chk("idle_P_valid", P_valid, 1);
    chk("idle_busy", busy, 0);

    // start and digit in the same cycle: digit not consumed
    start = 1'b1; ready_Zj = 1'b1; Zj = POS;
    tick();
    start = 1'b0; ready_Zj = 1'b0; Zj = ZRO;
    push_exp(11'h401);
    feed({10{NEG}}, 0, 10);
    wait_drain(); tick();

    // final digit with start: start wins, no done, P unchanged
    do_start();
    feed({10{POS}}, 0, 9);
    start = 1'b1; ready_Zj = 1'b1; Zj = POS;
    tick();
    start = 1'b0; ready_Zj = 1'b0; Zj = ZRO;
    chk("collide_no_done", done, 0);
    chk("collide_P", P, 11'h401);
    chk("collide_P_valid", P_valid, 0);
    chk("collide_busy", busy, 1);
    push_exp(11'h000);
    feed({10{ZRO}}, 0, 10);
    wait_drain(); tick();

    chk("done_count", done_cnt, push_cnt);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
